// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage and the ALU itself:
// ALU control codes, RV32I opcode constants, the issue entry and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_XOR = 4'd3,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd8,
    ALU_SLL = 4'd9,
    ALU_SRL = 4'd10,
    ALU_SRA = 4'd11
  } alu_ctrl_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // One decoded instruction as handed to the ALU.
  typedef struct packed {
    logic [31:0] data1;
    logic [31:0] data2;
    alu_ctrl_e   alu_ctrl;
    logic [4:0]  rd;
    logic        illegal;
  } issue_entry_t;

  localparam issue_entry_t ENTRY_RESET = '{
    data1:    32'd0,
    data2:    32'd0,
    alu_ctrl: ALU_AND,
    rd:       5'd0,
    illegal:  1'b0
  };

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } issue_state_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decode: instruction, PC and register operands in,
// one issue entry out. Unsupported encodings become a zero-operand ADD
// with the illegal flag set.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]  instr_i,
  input  logic [31:0]  pc_i,
  input  logic [31:0]  rs1_data_i,
  input  logic [31:0]  rs2_data_i,
  output issue_entry_t entry_o
);

  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic [31:0]  imm_i;
  logic [31:0]  imm_s;
  logic [31:0]  imm_u;
  logic [31:0]  shamt;
  logic         funct7_ok;
  logic         bad;
  issue_entry_t dec;

  assign opcode    = instr_i[6:0];
  assign funct3    = instr_i[14:12];
  assign funct7    = instr_i[31:25];
  assign imm_i     = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s     = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_u     = {instr_i[31:12], 12'b0};
  assign shamt     = {27'b0, instr_i[24:20]};
  assign funct7_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);

  // Select operands and ALU op per opcode; 'bad' marks unsupported encodings.
  always_comb begin
    // NOTE: every always_comb output is defaulted first so no path through the case leaves it unassigned (no latch).
    dec = '{data1: rs1_data_i, data2: rs2_data_i, alu_ctrl: ALU_ADD,
            rd: instr_i[11:7], illegal: 1'b0};
    bad = 1'b0;
    case (opcode)
      OPC_OP: begin
        bad = !funct7_ok;
        case (funct3)
          3'b000: if (funct7[5]) dec.alu_ctrl = ALU_SUB; else dec.alu_ctrl = ALU_ADD;
          3'b001: dec.alu_ctrl = ALU_SLL;
          3'b010: dec.alu_ctrl = ALU_SLT;
          3'b011: bad = 1'b1;  // SLTU
          3'b100: dec.alu_ctrl = ALU_XOR;
          3'b101: if (funct7[5]) dec.alu_ctrl = ALU_SRA; else dec.alu_ctrl = ALU_SRL;
          3'b110: dec.alu_ctrl = ALU_OR;
          3'b111: dec.alu_ctrl = ALU_AND;
        endcase
      end
      OPC_OP_IMM: begin
        dec.data2 = imm_i;
        case (funct3)
          3'b000: dec.alu_ctrl = ALU_ADD;
          3'b001: begin
            dec.alu_ctrl = ALU_SLL;
            dec.data2    = shamt;
            bad          = !funct7_ok;
          end
          3'b010: dec.alu_ctrl = ALU_SLT;
          3'b011: bad = 1'b1;  // SLTIU
          3'b100: dec.alu_ctrl = ALU_XOR;
          3'b101: begin
            if (funct7[5]) dec.alu_ctrl = ALU_SRA; else dec.alu_ctrl = ALU_SRL;
            dec.data2 = shamt;
            bad       = !funct7_ok;
          end
          3'b110: dec.alu_ctrl = ALU_OR;
          3'b111: dec.alu_ctrl = ALU_AND;
        endcase
      end
      OPC_LOAD:  dec.data2 = imm_i;
      OPC_STORE: dec.data2 = imm_s;
      OPC_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: dec.alu_ctrl = ALU_SUB;  // BEQ/BNE
          3'b100, 3'b101: dec.alu_ctrl = ALU_SLT;  // BLT/BGE
          default:        bad = 1'b1;              // BLTU/BGEU and reserved
        endcase
      end
      OPC_LUI: begin
        dec.data1 = 32'd0;
        dec.data2 = imm_u;
      end
      OPC_AUIPC: begin
        dec.data1 = pc_i;
        dec.data2 = imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        dec.data1 = pc_i;
        dec.data2 = 32'd4;
      end
      default: bad = 1'b1;
    endcase

    if (bad) begin
      dec.data1    = 32'd0;
      dec.data2    = 32'd0;
      dec.alu_ctrl = ALU_ADD;
      dec.illegal  = 1'b1;
    end
  end

  assign entry_o = dec;

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes the ID offer and holds up to two entries
// (head + skid) in strict FIFO order towards EX. All outputs come
// straight from registers.
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        flush_i,
  input  logic        ex_ready_i,
  output logic        valid_o,
  output logic [31:0] data1_o,
  output logic [31:0] data2_o,
  output logic [3:0]  ALUCtrl_o,
  output logic [4:0]  rd_o,
  output logic        illegal_o
);

  issue_state_e state;
  issue_entry_t dec_entry;
  issue_entry_t head;
  issue_entry_t skid;
  logic         accept;
  logic         pop;

  alu_decode u_decode (
    .instr_i    (instr_i),
    .pc_i       (pc_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .entry_o    (dec_entry)
  );

  assign accept = valid_i && ready_o && !flush_i;
  // A consume request with nothing presented is simply ignored.
  assign pop    = ex_ready_i && valid_o;

  // Buffer FSM: state, head entry and the registered handshake flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n_i) begin
      state   <= ST_EMPTY;
      head    <= ENTRY_RESET;
      valid_o <= 1'b0;
      ready_o <= 1'b0;
    end else if (flush_i) begin
      state   <= ST_EMPTY;
      valid_o <= 1'b0;
      ready_o <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          ready_o <= 1'b1;
          if (accept) begin
            head    <= dec_entry;
            state   <= ST_HALF;
            valid_o <= 1'b1;
          end
        end
        ST_HALF: begin
          case ({accept, pop})
            2'b10: begin
              state   <= ST_FULL;
              ready_o <= 1'b0;
            end
            2'b01: begin
              state   <= ST_EMPTY;
              valid_o <= 1'b0;
            end
            2'b11: head <= dec_entry;
            default: ;
          endcase
        end
        ST_FULL: begin
          if (pop) begin
            head    <= skid;
            state   <= ST_HALF;
            ready_o <= 1'b1;
          end
        end
        default: begin
          state   <= ST_EMPTY;
          valid_o <= 1'b0;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

  // Skid capture: HALF takes a second entry that EX did not consume.
  always_ff @(posedge clk_i) begin
    // NOTE: payload-only storage has no reset; the FSM state alone says whether it holds anything.
    if (state == ST_HALF && accept && !pop) begin
      skid <= dec_entry;
    end
  end

  assign data1_o   = head.data1;
  assign data2_o   = head.data2;
  assign ALUCtrl_o = head.alu_ctrl;
  assign rd_o      = head.rd;
  assign illegal_o = head.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios plus randomized traffic, checked
// against a queue-based FIFO model and an arithmetic RV32I decode model.
module tb_alu_issue;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        flush_i;
  logic        ex_ready_i;
  logic        valid_o;
  logic [31:0] data1_o;
  logic [31:0] data2_o;
  logic [3:0]  ALUCtrl_o;
  logic [4:0]  rd_o;
  logic        illegal_o;

  alu_issue dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .instr_i    (instr_i),
    .pc_i       (pc_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .flush_i    (flush_i),
    .ex_ready_i (ex_ready_i),
    .valid_o    (valid_o),
    .data1_o    (data1_o),
    .data2_o    (data2_o),
    .ALUCtrl_o  (ALUCtrl_o),
    .rd_o       (rd_o),
    .illegal_o  (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [3:0] C_AND = 4'd0, C_OR = 4'd1, C_ADD = 4'd2, C_XOR = 4'd3,
                         C_SUB = 4'd6, C_SLT = 4'd8, C_SLL = 4'd9, C_SRL = 4'd10,
                         C_SRA = 4'd11;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t        model_q[$];
  logic        model_ready;
  logic [31:0] popped[$];
  bit          last_accept;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference decode straight from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    logic [6:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    bit          legal;
    bit          f7_std;
    op     = ins[6:0];
    f7     = ins[31:25];
    f3     = ins[14:12];
    imm_i  = 32'($signed(ins) >>> 20);
    imm_s  = (imm_i & ~32'h1f) | {27'd0, ins[11:7]};
    f7_std = (f7 == 7'h00) || (f7 == 7'h20);
    legal  = 1'b1;
    r.rd   = ins[11:7];
    r.ill  = 1'b0;
    r.op   = C_ADD;
    r.d1   = a;
    r.d2   = b;
    case (op)
      7'h33: begin
        legal = f7_std;
        case (f3)
          3'd0: r.op = f7[5] ? C_SUB : C_ADD;
          3'd1: r.op = C_SLL;
          3'd2: r.op = C_SLT;
          3'd3: legal = 1'b0;
          3'd4: r.op = C_XOR;
          3'd5: r.op = f7[5] ? C_SRA : C_SRL;
          3'd6: r.op = C_OR;
          3'd7: r.op = C_AND;
        endcase
      end
      7'h13: begin
        r.d2 = imm_i;
        case (f3)
          3'd0: r.op = C_ADD;
          3'd1: begin r.op = C_SLL; r.d2 = {27'd0, ins[24:20]}; legal = f7_std; end
          3'd2: r.op = C_SLT;
          3'd3: legal = 1'b0;
          3'd4: r.op = C_XOR;
          3'd5: begin r.op = f7[5] ? C_SRA : C_SRL; r.d2 = {27'd0, ins[24:20]}; legal = f7_std; end
          3'd6: r.op = C_OR;
          3'd7: r.op = C_AND;
        endcase
      end
      7'h03: r.d2 = imm_i;
      7'h23: r.d2 = imm_s;
      7'h63: begin
        if (f3 == 3'd0 || f3 == 3'd1) r.op = C_SUB;
        else if (f3 == 3'd4 || f3 == 3'd5) r.op = C_SLT;
        else legal = 1'b0;
      end
      7'h37: begin r.d1 = 32'd0; r.d2 = {ins[31:12], 12'd0}; end
      7'h17: begin r.d1 = pc;    r.d2 = {ins[31:12], 12'd0}; end
      7'h6F, 7'h67: begin r.d1 = pc; r.d2 = 32'd4; end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      r.d1  = 32'd0;
      r.d2  = 32'd0;
      r.op  = C_ADD;
      r.ill = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int          k;
    ins = $urandom;
    k   = int'($urandom_range(0, 11));
    case (k)
      0, 1, 2: ins[6:0] = 7'h33;
      3, 4:    ins[6:0] = 7'h13;
      5:       ins[6:0] = 7'h03;
      6:       ins[6:0] = 7'h23;
      7:       ins[6:0] = 7'h63;
      8:       ins[6:0] = 7'h37;
      9:       ins[6:0] = 7'h17;
      10:      ins[6:0] = ($urandom_range(0, 1) != 0) ? 7'h6F : 7'h67;
      default: ;
    endcase
    k = int'($urandom_range(0, 3));
    if (k == 1) ins[31:25] = 7'h00;
    else if (k == 2) ins[31:25] = 7'h20;
    return ins;
  endfunction

  task automatic compare();
    check("valid_o", 32'(valid_o), 32'(model_q.size() > 0));
    check("ready_o", 32'(ready_o), 32'(model_ready));
    if (model_q.size() > 0) begin
      check("ALUCtrl_o", 32'(ALUCtrl_o), 32'(model_q[0].op));
      check("data1_o",   data1_o,         model_q[0].d1);
      check("data2_o",   data2_o,         model_q[0].d2);
      check("rd_o",      32'(rd_o),       32'(model_q[0].rd));
      check("illegal_o", 32'(illegal_o),  32'(model_q[0].ill));
    end
  endtask

  // One clock: drive at the falling edge, model at the rising edge, compare at the next falling edge.
  task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input bit fl, input bit exr);
    exp_t e;
    bit   acc;
    bit   pop;
    valid_i    = v;
    instr_i    = ins;
    pc_i       = $urandom;
    rs1_data_i = a;
    rs2_data_i = b;
    flush_i    = fl;
    ex_ready_i = exr;
    e   = ref_decode(ins, pc_i, a, b);
    acc = v && model_ready && !fl;
    pop = exr && (model_q.size() > 0);
    if (pop && !fl) popped.push_back(data2_o);
    last_accept = acc;
    @(posedge clk_i);
    if (fl) begin
      model_q.delete();
    end else begin
      if (pop) void'(model_q.pop_front());
      if (acc) model_q.push_back(e);
    end
    model_ready = (model_q.size() < 2);
    @(negedge clk_i);
    compare();
  endtask

  task automatic idle(input bit exr);
    cycle(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, exr);
  endtask

  // Assert reset between edges, check outputs clear at once, then release.
  task automatic do_reset();
    valid_i    = 1'b0;
    flush_i    = 1'b0;
    ex_ready_i = 1'b0;
    instr_i    = 32'd0;
    pc_i       = 32'd0;
    rs1_data_i = 32'd0;
    rs2_data_i = 32'd0;
    rst_n_i    = 1'b0;
    #1;
    check("rst.valid_o",   32'(valid_o),   32'd0);
    check("rst.ready_o",   32'(ready_o),   32'd0);
    check("rst.data1_o",   data1_o,        32'd0);
    check("rst.data2_o",   data2_o,        32'd0);
    check("rst.ALUCtrl_o", 32'(ALUCtrl_o), 32'd0);
    check("rst.rd_o",      32'(rd_o),      32'd0);
    check("rst.illegal_o", 32'(illegal_o), 32'd0);
    model_q.delete();
    model_ready = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    model_ready = 1'b1;
    @(negedge clk_i);
    compare();
  endtask

  function automatic logic [31:0] addi(input logic [11:0] imm, input logic [4:0] rd);
    return {imm, 5'd1, 3'b000, rd, 7'h13};
  endfunction

  initial begin
    logic [31:0] add_x3, srai4, addi_m1, sltu, blt;
    bit          got;
    add_x3  = {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33};
    srai4   = {7'h20, 5'd4, 5'd1, 3'b101, 5'd5, 7'h13};
    addi_m1 = addi(12'hFFF, 5'd6);
    sltu    = {7'h00, 5'd2, 5'd1, 3'b011, 5'd4, 7'h33};
    blt     = {7'h00, 5'd2, 5'd1, 3'b100, 5'd0, 7'h63};

    rst_n_i = 1'b1;
    #2;
    do_reset();

    // ADD x3,x1,x2 with 5 and 7: visible one cycle after the offer.
    cycle(1'b1, add_x3, 32'd5, 32'd7, 1'b0, 1'b0);
    check("add.valid", 32'(valid_o),   32'd1);
    check("add.ctrl",  32'(ALUCtrl_o), 32'd2);
    check("add.data1", data1_o,        32'd5);
    check("add.data2", data2_o,        32'd7);
    check("add.rd",    32'(rd_o),      32'd3);
    idle(1'b1);

    // SRAI shamt=4, then ADDI -1 replacing it in the head.
    cycle(1'b1, srai4, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
    check("srai.ctrl",  32'(ALUCtrl_o), 32'd11);
    check("srai.data2", data2_o,        32'd4);
    cycle(1'b1, addi_m1, 32'd9, 32'd0, 1'b0, 1'b1);
    check("addi.data2", data2_o, 32'hFFFF_FFFF);
    idle(1'b1);

    // Three back-to-back offers with EX stalled; then drain in order.
    popped.delete();
    cycle(1'b1, addi(12'd1, 5'd1), 32'd0, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, addi(12'd2, 5'd2), 32'd0, 32'd0, 1'b0, 1'b0);
    check("fifo.full_ready", 32'(ready_o), 32'd0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle(1'b1, addi(12'd3, 5'd3), 32'd0, 32'd0, 1'b0, 1'b1);
      got = last_accept;
    end
    check("fifo.third_accepted", 32'(got), 32'd1);
    repeat (3) idle(1'b1);
    check("fifo.count", 32'(popped.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("fifo.order", (i < popped.size()) ? popped[i] : 32'hDEAD_BEEF, 32'(i + 1));
    end

    // Flush while FULL with a simultaneous offer.
    cycle(1'b1, addi(12'd7, 5'd7), 32'd1, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, addi(12'd8, 5'd8), 32'd1, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, addi(12'd9, 5'd9), 32'd1, 32'd0, 1'b1, 1'b1);
    check("flush.valid", 32'(valid_o), 32'd0);
    check("flush.ready", 32'(ready_o), 32'd1);
    idle(1'b0);
    check("flush.lost", 32'(valid_o), 32'd0);

    // SLTU is illegal; BLT maps to SLT.
    cycle(1'b1, sltu, 32'd123, 32'd456, 1'b0, 1'b0);
    check("sltu.illegal", 32'(illegal_o), 32'd1);
    check("sltu.ctrl",    32'(ALUCtrl_o), 32'd2);
    check("sltu.data1",   data1_o,        32'd0);
    check("sltu.data2",   data2_o,        32'd0);
    cycle(1'b1, blt, 32'd3, 32'd4, 1'b0, 1'b1);
    check("blt.ctrl",    32'(ALUCtrl_o), 32'd8);
    check("blt.illegal", 32'(illegal_o), 32'd0);
    idle(1'b1);

    // Reset pulsed while FULL.
    cycle(1'b1, add_x3, 32'd11, 32'd12, 1'b0, 1'b0);
    cycle(1'b1, add_x3, 32'd13, 32'd14, 1'b0, 1'b0);
    #2;
    do_reset();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom,
            $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 clk_i  input  1  rising-edge clock, sole clock domain.
REQ-002 rst_n_i  input  1  asynchronous, active-low reset.
REQ-003 valid_i  input  1  upstream (ID) offers an instruction this cycle.
REQ-004 ready_o  output  1  block accepts the offer; registered, equals "not FULL".
REQ-005 instr_i  input  32  RV32I instruction word.
REQ-006 pc_i, rs1_data_i, rs2_data_i  input  32 each  PC and register-file read data.
REQ-007 flush_i  input  1  discard all held and incoming entries.
REQ-008 ex_ready_i  input  1  EX stage consumes the head entry this cycle.
REQ-009 valid_o  output  1  head entry presented to EX.
REQ-010 data1_o, data2_o  output  32 each  ALU operands (two's complement).
REQ-011 ALUCtrl_o  output  4  ALU op: ADD=2, SUB=6, AND=0, OR=1, XOR=3, SLT=8, SLL=9, SRL=10, SRA=11.
REQ-012 rd_o  output  5  destination register, instr[11:7].
REQ-013 illegal_o  output  1  head entry is an unsupported encoding.

Function
REQ-014 Decode is combinational on instr_i and is captured only on accept (valid_i && ready_o && !flush_i).
REQ-015 OP (0110011): data1=rs1, data2=rs2; funct3 000 ADD or SUB (funct7[5]), 001 SLL, 010 SLT, 100 XOR, 101 SRL or SRA (funct7[5]), 110 OR, 111 AND.
REQ-016 OP-IMM (0010011): data2=sign-extended I-imm; funct3 000 always ADD; shifts use data2={27'b0,shamt}.
REQ-017 LOAD (0000011) / STORE (0100011): ADD, data2 = I-imm / S-imm sign-extended.
REQ-018 BRANCH (1100011): data1=rs1, data2=rs2; BEQ/BNE -> SUB; BLT/BGE -> SLT.
REQ-019 LUI: ADD, data1=0, data2={imm[31:12],12'b0}; AUIPC: ADD, data1=pc, data2=U-imm.
REQ-020 JAL/JALR: ADD, data1=pc, data2=32'd4.
REQ-021 Illegal: SLTU/SLTIU, BLTU/BGEU, branch funct3 010/011, funct7 not in {0000000,0100000} for OP or OP-IMM shifts, any other opcode; entry issued with illegal_o=1, ALUCtrl=ADD, data1=data2=0.
REQ-022 Buffer is 2 entries (head + skid); FSM states EMPTY, HALF, FULL.
REQ-023 EMPTY: accept -> HALF, valid_o=1 the next cycle (latency 1).
REQ-024 HALF: accept && !ex_ready_i -> FULL (new entry to skid); ex_ready_i && !accept -> EMPTY; both -> HALF with new entry in head.
REQ-025 FULL: ready_o=0; ex_ready_i -> HALF, skid moves to head the same edge; order strictly FIFO.
REQ-026 ex_ready_i while valid_o=0 is ignored; EX may deassert ex_ready_i arbitrarily.
REQ-027 flush_i: next state EMPTY, valid_o=0 next cycle, same-cycle offer dropped; flush dominates accept and ex_ready_i.
REQ-028 Outputs are driven only from registers; no combinational path from inputs to outputs.

Reset
REQ-029 rst_n_i low -> state EMPTY, valid_o=0, ready_o=0 while asserted, 1 from the first edge after release; data1_o, data2_o, ALUCtrl_o, rd_o, illegal_o = 0.
REQ-030 Reset mid-operation discards both entries without handshake.

Structure
REQ-031 Package alu_pkg holds ALUCtrl codes, opcode constants and the entry struct; shared with the ALU.
REQ-032 One sub-module, alu_decode (combinational instr/pc/rs -> entry); alu_issue holds the FSM and buffer.

Verification
REQ-033 EMPTY, ADD x3,x1,x2 with rs1=5, rs2=7 -> next cycle valid_o=1, ALUCtrl=2, data1=5, data2=7, rd=3.
REQ-034 SRAI shamt=4 (funct7=0100000) -> ALUCtrl=11, data2=4; ADDI imm=0xFFF -> data2=0xFFFFFFFF.
REQ-035 ex_ready_i=0, three back-to-back offers -> ready_o=0 after two accepts; ex_ready_i=1 -> entries emerge in order 1,2,3.
REQ-036 FULL plus flush_i with valid_i=1 -> next cycle valid_o=0, ready_o=1, offer lost.
REQ-037 SLTU instruction -> illegal_o=1, ALUCtrl=2, data1=data2=0; BLT -> ALUCtrl=8, illegal_o=0.
REQ-038 rst_n_i pulsed low in FULL between edges -> immediately valid_o=0 and all outputs 0.
